// File: rtl/l1a_match_rcvr_if.sv
// ---------------------------------------------------------------------------
// l1a_match_rcvr_if
//   Bundle between the trigger-control / readout-sequencer side and the
//   L1A match receiver.
//
//   master : trigger control + readout sequencer (drives L1A, L1A_MATCH, RD)
//   slave  : l1a_match_rcvr (drives DAV, DOUT, FULL, OVFL, DROPCNT)
//
//   L1A        L1A strobe, one-cycle pulse per event
//   L1A_MATCH  per-FEB match pulses {CFEB5..CFEB1, ALCT}
//   RD         pop strobe from the readout sequencer
//   DAV        FIFO non-empty; DOUT valid while high
//   DOUT       {TRUNC, L1ANUM[L1A_W-1:0], MATCH[5:0]} of the head entry
//   FULL       FIFO holds its maximum number of entries
//   OVFL       sticky drop flag
//   DROPCNT    saturating count of dropped entries
// ---------------------------------------------------------------------------
interface l1a_match_rcvr_if #(
  parameter int L1A_W = 24
);
  logic             L1A;
  logic [5:0]       L1A_MATCH;
  logic             RD;
  logic             DAV;
  logic [L1A_W+6:0] DOUT;
  logic             FULL;
  logic             OVFL;
  logic [7:0]       DROPCNT;

  modport master (
    output L1A, L1A_MATCH, RD,
    input  DAV, DOUT, FULL, OVFL, DROPCNT
  );

  modport slave (
    input  L1A, L1A_MATCH, RD,
    output DAV, DOUT, FULL, OVFL, DROPCNT
  );
endinterface

// File: rtl/l1a_match_rcvr.sv
// ---------------------------------------------------------------------------
// l1a_match_rcvr
//   Receiving end of the trigger-control L1A/match interface. After every L1A
//   the six per-FEB L1A_MATCH bits are ORed over a window of MATCH_WIN clock
//   cycles (starting with the L1A cycle itself). The result is tagged with
//   the L1A event number and pushed into a show-ahead FIFO that the readout
//   sequencer pops once per event.
//
//   A new L1A arriving while a window is still open closes the current entry
//   early (TRUNC=1, only the bits gathered so far) and opens a fresh window.
//
// Ports
//   CLK   system clock, rising edge
//   RST   synchronous active-high reset; flushes the FIFO, discards any open
//         window, restarts the L1A counter and clears OVFL/DROPCNT
//   bus   l1a_match_rcvr_if.slave:
//           in : L1A, L1A_MATCH[5:0], RD
//           out: DAV, DOUT[L1A_W+6:0], FULL, OVFL, DROPCNT[7:0]
//
// Parameters
//   MATCH_WIN  window length in CLK cycles (2..15)
//   FIFO_AW    FIFO address width, depth = 2**FIFO_AW
//   L1A_W      width of the L1A event counter
// ---------------------------------------------------------------------------
module l1a_match_rcvr #(
  parameter int MATCH_WIN = 4,
  parameter int FIFO_AW   = 4,
  parameter int L1A_W     = 24
) (
  input logic             CLK,
  input logic             RST,
  l1a_match_rcvr_if.slave bus
);

  localparam int DW    = L1A_W + 7;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    WINDOW = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Window FSM and L1A counter
  // ---------------------------------------------------------------------
  state_t           state;
  logic [3:0]       wcnt;
  logic [5:0]       acc;
  logic [L1A_W-1:0] l1a_cnt;
  logic [L1A_W-1:0] cur_num;

  logic             wr_en;
  logic [DW-1:0]    wr_data;

  // The write has to land in the same cycle the window closes (or is cut
  // short by a new L1A), so the write request is decoded from the current
  // FSM state rather than registered a cycle later.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = {1'b0, cur_num, acc};
    if (state == WINDOW) begin
      if (wcnt == 4'(MATCH_WIN)) begin
        // Window complete. A coincident L1A still starts a new window, but
        // this entry saw its full window so it is not marked truncated.
        wr_en = 1'b1;
      end else if (bus.L1A) begin
        wr_en   = 1'b1;
        wr_data = {1'b1, cur_num, acc};
      end
    end
  end

  always_ff @(posedge CLK) begin
    // Datapath registers carry no reset: acc and cur_num are only consumed
    // while in WINDOW, and every entry into WINDOW reloads them.
    if (bus.L1A) begin
      acc     <= bus.L1A_MATCH;
      cur_num <= l1a_cnt;
    end else begin
      acc     <= acc | bus.L1A_MATCH;
    end

    if (RST) begin
      state   <= IDLE;
      wcnt    <= '0;
      l1a_cnt <= '0;
    end else begin
      // Every L1A consumes a number, whether or not its entry survives.
      if (bus.L1A) begin
        l1a_cnt <= l1a_cnt + L1A_W'(1);
      end

      case (state)
        IDLE: begin
          if (bus.L1A) begin
            state <= WINDOW;
            wcnt  <= 4'd1;
          end
        end
        WINDOW: begin
          if (bus.L1A) begin
            wcnt <= 4'd1;
          end else if (wcnt == 4'(MATCH_WIN)) begin
            state <= IDLE;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------
  logic [DW-1:0]    mem [DEPTH];
  logic [FIFO_AW:0] wptr;
  logic [FIFO_AW:0] rptr;
  logic [DW-1:0]    last;
  logic [7:0]       dropcnt;
  logic             ovfl;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // One extra pointer bit distinguishes full from empty when the address
  // bits coincide.
  assign empty = (wptr == rptr);
  assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                 (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);

  assign pop  = bus.RD && !empty;
  // A pop in the same cycle frees the slot, so a write while full still fits.
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wptr[FIFO_AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr    <= '0;
      rptr    <= '0;
      last    <= '0;
      ovfl    <= 1'b0;
      dropcnt <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + (FIFO_AW + 1)'(1);
      end
      if (pop) begin
        rptr <= rptr + (FIFO_AW + 1)'(1);
        // Keep a copy of the entry leaving the head so DOUT can keep showing
        // it once the FIFO runs empty.
        last <= mem[rptr[FIFO_AW-1:0]];
      end
      if (drop) begin
        ovfl <= 1'b1;
        if (dropcnt != 8'hFF) begin
          dropcnt <= dropcnt + 8'd1;
        end
      end
    end
  end

  assign bus.DAV     = !empty;
  assign bus.DOUT    = empty ? last : mem[rptr[FIFO_AW-1:0]];
  assign bus.FULL    = full;
  assign bus.OVFL    = ovfl;
  assign bus.DROPCNT = dropcnt;

endmodule
